// File: rtl/hc595_ctrl.sv
// Serial driver for a chain of 74HC595 shift registers.
// Shifts a frame out MSB first, then pulses rck, or clears the chain via sclr_n.
//
// state  | meaning
// IDLE   | waiting for a frame or clear request; ready=1
// SCK_LO | sck low phase, si holds the current bit
// SCK_HI | sck high phase, device samples si on the rising edge
// CLEAR  | sclr_n held low for one phase
// RCK_LO | rck low phase before the latch pulse
// RCK_HI | rck high phase; done pulses on exit
module hc595_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  input  logic             clr,
  input  logic             oe,
  output logic             done,
  output logic             si,
  output logic             sck,
  output logic             rck,
  output logic             sclr_n,
  output logic             g_n
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCK_LO = 3'd1,
    SCK_HI = 3'd2,
    CLEAR  = 3'd3,
    RCK_LO = 3'd4,
    RCK_HI = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DW-1:0]    div_cnt;
  logic             phase_end;
  logic             si_nxt, sck_nxt, rck_nxt, sclr_n_nxt, done_nxt;

  assign phase_end = (div_cnt == DIV_LAST);
  assign ready     = (state == IDLE);

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    si_nxt      = si;
    sck_nxt     = sck;
    rck_nxt     = rck;
    sclr_n_nxt  = sclr_n;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        sck_nxt    = 1'b0;
        rck_nxt    = 1'b0;
        sclr_n_nxt = 1'b1;
        // clr wins over valid; the frame is simply not taken
        if (clr) begin
          sclr_n_nxt = 1'b0;
          state_nxt  = CLEAR;
        end else if (valid) begin
          shreg_nxt   = data;
          si_nxt      = data[WIDTH-1];
          bit_cnt_nxt = '0;
          state_nxt   = SCK_LO;
        end
      end

      SCK_LO: begin
        if (phase_end) begin
          sck_nxt   = 1'b1;
          state_nxt = SCK_HI;
        end
      end

      SCK_HI: begin
        if (phase_end) begin
          sck_nxt = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = RCK_LO;
          end else begin
            // si moves only on the sck falling edge
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = shreg << 1;
            si_nxt      = shreg_nxt[WIDTH-1];
            state_nxt   = SCK_LO;
          end
        end
      end

      CLEAR: begin
        sclr_n_nxt = 1'b0;
        if (phase_end) begin
          sclr_n_nxt = 1'b1;
          state_nxt  = RCK_LO;
        end
      end

      RCK_LO: begin
        if (phase_end) begin
          rck_nxt   = 1'b1;
          state_nxt = RCK_HI;
        end
      end

      RCK_HI: begin
        if (phase_end) begin
          rck_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      si      <= 1'b0;
      sck     <= 1'b0;
      rck     <= 1'b0;
      sclr_n  <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      si      <= si_nxt;
      sck     <= sck_nxt;
      rck     <= rck_nxt;
      sclr_n  <= sclr_n_nxt;
      done    <= done_nxt;
    end
  end

  // Phase timer restarts on every state change and idles at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if ((state_nxt != state) || (state_nxt == IDLE)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_n <= 1'b1;
    end else begin
      g_n <= ~oe;
    end
  end

endmodule

// File: tb/tb_hc595_ctrl.sv
// Directed bench for hc595_ctrl with WIDTH=8, DIV=2.
// A negedge monitor counts pin edges; the main sequence checks timing against hand-computed values.
module tb_hc595_ctrl;

  localparam int WIDTH = 8;
  localparam int DIV   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             clr;
  logic             oe;
  logic             done;
  logic             si;
  logic             sck;
  logic             rck;
  logic             sclr_n;
  logic             g_n;

  int n_chk  = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_sck_rise = 0;
  int n_rck_rise = 0;
  int n_sclr_lo  = 0;
  int n_done     = 0;
  int last_sck_fall_cyc = 0;
  int rck_rise_cyc      = 0;
  logic [7:0] frame_si  = 8'h00;
  logic sck_q = 1'b0;
  logic rck_q = 1'b0;

  hc595_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .clr    (clr),
    .oe     (oe),
    .done   (done),
    .si     (si),
    .sck    (sck),
    .rck    (rck),
    .sclr_n (sclr_n),
    .g_n    (g_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sck && !sck_q) begin
      n_sck_rise = n_sck_rise + 1;
      frame_si   = {frame_si[6:0], si};
    end
    if (!sck && sck_q) last_sck_fall_cyc = cyc;
    if (rck && !rck_q) begin
      n_rck_rise   = n_rck_rise + 1;
      rck_rise_cyc = cyc;
    end
    if (!sclr_n) n_sclr_lo = n_sclr_lo + 1;
    if (done) n_done = n_done + 1;
    sck_q = sck;
    rck_q = rck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        at = cyc;
        break;
      end
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  int t0, d1, d2;
  int b_sck, b_rck, b_sclr, b_done;

  initial begin
    rst = 1'b1; data = '0; valid = 1'b0; clr = 1'b0; oe = 1'b0;
    repeat (2) step();
    chk("rst_sck",    {31'b0, sck},    32'd0);
    chk("rst_rck",    {31'b0, rck},    32'd0);
    chk("rst_si",     {31'b0, si},     32'd0);
    chk("rst_sclr_n", {31'b0, sclr_n}, 32'd1);
    chk("rst_g_n",    {31'b0, g_n},    32'd1);
    chk("rst_done",   {31'b0, done},   32'd0);
    chk("rst_ready",  {31'b0, ready},  32'd1);
    rst = 1'b0;
    step();

    // Frame 0xB5
    b_sck = n_sck_rise; b_rck = n_rck_rise; b_done = n_done;
    data = 8'hB5; valid = 1'b1; t0 = cyc + 1;
    step();
    chk("a_busy", {31'b0, ready}, 32'd0);
    valid = 1'b0;
    wait_done("a_done_seen", 100, d1);
    chk("a_done_lat",  d1 - t0, 32'd36);
    chk("a_sck_rises", n_sck_rise - b_sck, 32'd8);
    chk("a_rck_rises", n_rck_rise - b_rck, 32'd1);
    chk("a_si_bits",   {24'b0, frame_si}, 32'h0000_00B5);
    chk("a_rck_after_fall", rck_rise_cyc - last_sck_fall_cyc, 32'd2);
    chk("a_ready_in_done", {31'b0, ready}, 32'd1);
    step();
    chk("a_done_width", {31'b0, done}, 32'd0);
    chk("a_done_count", n_done - b_done, 32'd1);

    // Clear and valid together: clear wins
    b_sck = n_sck_rise; b_rck = n_rck_rise; b_sclr = n_sclr_lo;
    data = 8'h55; valid = 1'b1; clr = 1'b1; t0 = cyc + 1;
    step();
    valid = 1'b0; clr = 1'b0;
    wait_done("b_done_seen", 100, d1);
    chk("b_done_lat",  d1 - t0, 32'd6);
    chk("b_sclr_lo",   n_sclr_lo - b_sclr, 32'd2);
    chk("b_rck_rises", n_rck_rise - b_rck, 32'd1);
    chk("b_sck_rises", n_sck_rise - b_sck, 32'd0);
    chk("b_si_kept",   {31'b0, si}, 32'd1);
    step();

    // Back-to-back frames with valid held high
    b_sck = n_sck_rise; b_rck = n_rck_rise;
    data = 8'hFF; valid = 1'b1; t0 = cyc + 1;
    wait_done("c_done1_seen", 100, d1);
    chk("c_done1_lat", d1 - t0, 32'd36);
    data = 8'h00;
    step();
    chk("c_second_busy", {31'b0, ready}, 32'd0);
    valid = 1'b0;
    wait_done("c_done2_seen", 100, d2);
    chk("c_done_gap",  d2 - d1, 32'd37);
    chk("c_sck_rises", n_sck_rise - b_sck, 32'd16);
    chk("c_rck_rises", n_rck_rise - b_rck, 32'd2);
    chk("c_si_bits",   {24'b0, frame_si}, 32'h0000_0000);
    step();

    // Requests while busy are dropped; oe toggled mid-frame
    b_sck = n_sck_rise; b_rck = n_rck_rise; b_sclr = n_sclr_lo; b_done = n_done;
    data = 8'h3C; valid = 1'b1; t0 = cyc + 1;
    step();
    valid = 1'b0;
    step();
    data = 8'hFF; valid = 1'b1; clr = 1'b1;
    step();
    valid = 1'b0; clr = 1'b0; oe = 1'b1;
    step();
    chk("e_g_n_low", {31'b0, g_n}, 32'd0);
    oe = 1'b0;
    step();
    chk("e_g_n_high", {31'b0, g_n}, 32'd1);
    wait_done("e_done_seen", 100, d1);
    chk("e_done_lat",  d1 - t0, 32'd36);
    chk("e_sck_rises", n_sck_rise - b_sck, 32'd8);
    chk("e_rck_rises", n_rck_rise - b_rck, 32'd1);
    chk("e_sclr_lo",   n_sclr_lo - b_sclr, 32'd0);
    chk("e_si_bits",   {24'b0, frame_si}, 32'h0000_003C);
    chk("e_done_count", n_done - b_done, 32'd1);
    step();

    // Reset after the third sck rise
    b_sck = n_sck_rise; b_rck = n_rck_rise; b_done = n_done;
    data = 8'hA5; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_sck_rise - b_sck >= 3) break;
      step();
    end
    chk("f_third_rise", n_sck_rise - b_sck, 32'd3);
    chk("f_sck_high",   {31'b0, sck}, 32'd1);
    rst = 1'b1; oe = 1'b1; valid = 1'b1; clr = 1'b1;
    step();
    chk("f_sck",    {31'b0, sck},    32'd0);
    chk("f_rck",    {31'b0, rck},    32'd0);
    chk("f_ready",  {31'b0, ready},  32'd1);
    chk("f_g_n",    {31'b0, g_n},    32'd1);
    chk("f_sclr_n", {31'b0, sclr_n}, 32'd1);
    chk("f_si",     {31'b0, si},     32'd0);
    rst = 1'b0; oe = 1'b0; valid = 1'b0; clr = 1'b0;
    repeat (60) step();
    chk("f_no_more_sck", n_sck_rise - b_sck, 32'd3);
    chk("f_no_rck",      n_rck_rise - b_rck, 32'd0);
    chk("f_no_done",     n_done - b_done,    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
